// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared command codes, RAM operation codes and FSM states for the stack controller
package stack_ctrl_pkg;
   localparam int STACK_CMD_LEN = 3;
   localparam int RAM_OP_LEN = 2;
   typedef enum logic [STACK_CMD_LEN-1:0] {
      CMD_NOP = 3'd0, CMD_PUSH = 3'd1, CMD_POP = 3'd2, CMD_CALL = 3'd3, CMD_RET = 3'd4, CMD_SP_WR = 3'd5
   } stack_cmd_e;
   typedef enum logic [RAM_OP_LEN-1:0] {
      OP_RAM_NOP = 2'd0, OP_RAM_WR_BYTE = 2'd1, OP_RAM_RD_BYTE = 2'd2
   } ram_op_e;
   typedef enum logic [1:0] {ST_IDLE, ST_XFER1, ST_XFER2, ST_DONE} state_e;
   // commands that touch the RAM and therefore pass through the transfer states
   function automatic logic is_xfer(input logic [STACK_CMD_LEN-1:0] c);
      return c inside {CMD_PUSH, CMD_POP, CMD_CALL, CMD_RET};
   endfunction
endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl: stack pointer FSM issuing byte RAM accesses for PUSH/POP/CALL/RET/SP_WR
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter logic [7:0] SP_RESET = 8'h07
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [STACK_CMD_LEN-1:0] i_cmd,
   input  logic [7:0]               i_wr_byte,
   input  logic [15:0]              i_pc,
   input  logic [7:0]               i_ram_byte,
   output logic [RAM_OP_LEN-1:0]    o_ram_op,
   output logic [7:0]               o_ram_addr,
   output logic [7:0]               o_ram_addr_r,
   output logic [7:0]               o_ram_wr_byte,
   output logic [7:0]               o_sp,
   output logic [7:0]               o_data,
   output logic [15:0]              o_pc,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_wrap
);
   state_e                   state;
   logic [STACK_CMD_LEN-1:0] cmd_q;
   logic [7:0]               byte_q;
   logic [15:0]              pc_q;
   logic                     wrap_q;
   logic                     is_wr, is_rd, xfer, wrap_now;
   logic [7:0]               sp_nxt;

   // writes always go one above SP and reads at SP, so a CALL/RET second byte needs no extra address logic
   always_comb begin
      xfer          = state == ST_XFER1 || state == ST_XFER2;
      is_wr         = cmd_q == CMD_PUSH || cmd_q == CMD_CALL;
      is_rd         = cmd_q == CMD_POP || cmd_q == CMD_RET;
      sp_nxt        = is_wr ? o_sp + 8'd1 : o_sp - 8'd1;
      wrap_now      = is_wr ? o_sp == 8'hFF : o_sp == 8'h00;
      o_ram_op      = (!i_rst_n || !xfer) ? OP_RAM_NOP : is_wr ? OP_RAM_WR_BYTE : is_rd ? OP_RAM_RD_BYTE : OP_RAM_NOP;
      o_ram_addr    = o_sp + 8'd1;
      o_ram_addr_r  = o_sp;
      o_ram_wr_byte = cmd_q != CMD_CALL ? byte_q : state == ST_XFER1 ? pc_q[7:0] : pc_q[15:8];
      o_busy        = state != ST_IDLE;
   end

   // command sequencer; RET parks the high byte in byte_q so o_pc changes only once both bytes are in
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state  <= ST_IDLE;
         o_sp   <= SP_RESET;
         o_data <= 8'h00;
         o_pc   <= 16'h0000;
         o_done <= 1'b0;
         o_wrap <= 1'b0;
         wrap_q <= 1'b0;
         cmd_q  <= CMD_NOP;
      end else begin
         o_done <= 1'b0;
         o_wrap <= 1'b0;
         case (state)
            ST_IDLE: if (i_start) begin
               cmd_q  <= i_cmd;
               byte_q <= i_wr_byte;
               pc_q   <= i_pc;
               wrap_q <= 1'b0;
               if (is_xfer(i_cmd)) state <= ST_XFER1;
               else begin
                  state  <= ST_DONE;
                  o_done <= 1'b1;
                  if (i_cmd == CMD_SP_WR) o_sp <= i_wr_byte;
               end
            end
            ST_XFER1: begin
               o_sp   <= sp_nxt;
               wrap_q <= wrap_now;
               if (cmd_q == CMD_POP) o_data <= i_ram_byte;
               if (cmd_q == CMD_RET) byte_q <= i_ram_byte;
               if (cmd_q == CMD_CALL || cmd_q == CMD_RET) state <= ST_XFER2;
               else begin
                  state  <= ST_DONE;
                  o_done <= 1'b1;
                  o_wrap <= wrap_now;
               end
            end
            ST_XFER2: begin
               o_sp   <= sp_nxt;
               if (cmd_q == CMD_RET) o_pc <= {byte_q, i_ram_byte};
               state  <= ST_DONE;
               o_done <= 1'b1;
               o_wrap <= wrap_q | wrap_now;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: random and directed commands checked against an abstract stack model
module tb_stack_ctrl;
   import stack_ctrl_pkg::*;
   logic        clk = 0, rst_n = 0, start = 0;
   logic [2:0]  cmd = 0;
   logic [7:0]  wr_byte = 0;
   logic [15:0] pc = 0;
   logic [7:0]  ram_byte, ram_addr, ram_addr_r, ram_wr_byte, sp, data;
   logic [1:0]  ram_op;
   logic [15:0] opc;
   logic        busy, done, wrap;
   logic [7:0]  mem [256];
   logic        seed_we = 0;
   logic [7:0]  seed_addr = 0, seed_val = 0;
   int          n_wr = 0, n_rd = 0;
   logic [7:0]  m_mem [256];
   logic [7:0]  m_sp, m_data;
   logic [15:0] m_pc;
   logic        m_wrap;
   int          cmps = 0, errs = 0;

   stack_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_cmd(cmd), .i_wr_byte(wr_byte), .i_pc(pc),
      .i_ram_byte(ram_byte), .o_ram_op(ram_op), .o_ram_addr(ram_addr), .o_ram_addr_r(ram_addr_r),
      .o_ram_wr_byte(ram_wr_byte), .o_sp(sp), .o_data(data), .o_pc(opc), .o_busy(busy),
      .o_done(done), .o_wrap(wrap)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (seed_we) mem[seed_addr] <= seed_val;
      else if (ram_op == OP_RAM_WR_BYTE) begin
         mem[ram_addr] <= ram_wr_byte;
         n_wr <= n_wr + 1;
      end
      if (ram_op == OP_RAM_RD_BYTE) n_rd <= n_rd + 1;
   end
   assign ram_byte = mem[ram_addr_r];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      cmps++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic seed(input logic [7:0] a, input logic [7:0] v);
      @(negedge clk);
      seed_we = 1; seed_addr = a; seed_val = v; m_mem[a] = v;
      @(negedge clk);
      seed_we = 0;
   endtask

   function automatic void m_push(input logic [7:0] v);
      if (m_sp == 8'hFF) m_wrap = 1;
      m_sp = m_sp + 8'd1;
      m_mem[m_sp] = v;
   endfunction

   function automatic logic [7:0] m_pop();
      logic [7:0] v = m_mem[m_sp];
      if (m_sp == 8'h00) m_wrap = 1;
      m_sp = m_sp - 8'd1;
      return v;
   endfunction

   task automatic run_cmd(input logic [2:0] c, input logic [7:0] b, input logic [15:0] p, input bit inject);
      int lat, w0, r0, exp_lat, exp_wr, exp_rd;
      logic [7:0] hi, lo;
      m_wrap = 0; exp_lat = 1; exp_wr = 0; exp_rd = 0;
      case (c)
         CMD_PUSH: begin m_push(b); exp_lat = 2; exp_wr = 1; end
         CMD_CALL: begin m_push(p[7:0]); m_push(p[15:8]); exp_lat = 3; exp_wr = 2; end
         CMD_POP: begin m_data = m_pop(); exp_lat = 2; exp_rd = 1; end
         CMD_RET: begin hi = m_pop(); lo = m_pop(); m_pc = {hi, lo}; exp_lat = 3; exp_rd = 2; end
         CMD_SP_WR: m_sp = b;
         default: ;
      endcase
      @(negedge clk);
      start = 1; cmd = c; wr_byte = b; pc = p;
      w0 = n_wr; r0 = n_rd; lat = 0;
      while (lat < 10) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) start = 0;
         if (inject && lat == 1) begin start = 1; cmd = CMD_POP; end
         if (lat == 2) start = 0;
         if (done) break;
      end
      start = 0;
      check($sformatf("lat cmd%0d", c), lat, exp_lat);
      check("sp", sp, m_sp);
      check("wrap", wrap, m_wrap);
      check("data", data, m_data);
      check("pc", opc, m_pc);
      check("writes", n_wr - w0, exp_wr);
      check("reads", n_rd - r0, exp_rd);
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("idle", busy, 0);
      check("idle_op", ram_op, OP_RAM_NOP);
      check("mem_sp", mem[m_sp], m_mem[m_sp]);
      check("mem_sp_m1", mem[m_sp - 8'd1], m_mem[m_sp - 8'd1]);
   endtask

   initial begin
      int diffs;
      for (int i = 0; i < 256; i++) seed(8'(i), 8'($urandom));
      @(posedge clk); #1;
      check("rst_sp", sp, 8'h07);
      check("rst_data", data, 0);
      check("rst_pc", opc, 0);
      check("rst_done", done, 0);
      check("rst_wrap", wrap, 0);
      check("rst_busy", busy, 0);
      check("rst_op", ram_op, OP_RAM_NOP);
      m_sp = 8'h07; m_data = 0; m_pc = 0;
      @(negedge clk); rst_n = 1;
      run_cmd(CMD_PUSH, 8'hA5, 16'h0, 0);
      check("push_a5_at_08", mem[8], 8'hA5);
      run_cmd(CMD_SP_WR, 8'h07, 16'h0, 0);
      run_cmd(CMD_CALL, 8'h00, 16'h1234, 0);
      check("call_lo_at_08", mem[8], 8'h34);
      check("call_hi_at_09", mem[9], 8'h12);
      run_cmd(CMD_RET, 8'h00, 16'h0, 0);
      check("ret_pc", opc, 16'h1234);
      run_cmd(CMD_SP_WR, 8'hFF, 16'h0, 0);
      run_cmd(CMD_PUSH, 8'h5A, 16'h0, 0);
      check("wrap_push_at_00", mem[0], 8'h5A);
      run_cmd(CMD_POP, 8'h00, 16'h0, 0);
      check("wrap_pop_data", data, 8'h5A);
      run_cmd(CMD_SP_WR, 8'h07, 16'h0, 0);
      run_cmd(CMD_CALL, 8'h00, 16'hBEEF, 1);
      run_cmd(CMD_SP_WR, 8'h07, 16'h0, 0);
      seed(8'h09, 8'hEE);
      @(negedge clk);
      start = 1; cmd = CMD_CALL; pc = 16'h1234;
      @(posedge clk); #1;
      start = 0;
      @(posedge clk); #1;
      rst_n = 0;
      #1 check("rst_forces_nop", ram_op, OP_RAM_NOP);
      @(posedge clk); #1;
      m_mem[8] = 8'h34; m_sp = 8'h07; m_data = 0; m_pc = 0;
      check("abort_sp", sp, 8'h07);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      check("abort_09", mem[9], 8'hEE);
      check("abort_08", mem[8], 8'h34);
      check("abort_pc", opc, 0);
      @(negedge clk); rst_n = 1;
      repeat (300) run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) diffs++;
      check("mem_all", diffs, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter SP_RESET, default 8'h07, stack pointer value after reset.
REQ-002 SHALL have i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have i_rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have i_start  input  1  command request, sampled only in IDLE.
REQ-005 SHALL have i_cmd  input  `STACK_CMD_LEN  command: NOP, PUSH, POP, CALL, RET, SP_WR.
REQ-006 SHALL have i_wr_byte  input  8  PUSH data or new SP value for SP_WR.
REQ-007 SHALL have i_pc  input  16  return address pushed by CALL.
REQ-008 SHALL have i_ram_byte  input  8  combinational read data from internal RAM.
REQ-009 SHALL have o_ram_op  output  `RAM_OP_LEN  RAM operation: OP_RAM_NOP, OP_RAM_WR_BYTE or OP_RAM_RD_BYTE only.
REQ-010 SHALL have o_ram_addr, o_ram_addr_r, o_ram_wr_byte  output  8 each  RAM write address, read address, write data.
REQ-011 SHALL have o_sp  output  8  current stack pointer.
REQ-012 SHALL have o_data  output  8  byte returned by POP; o_pc  output  16  address returned by RET.
REQ-013 SHALL have o_busy, o_done, o_wrap  output  1 each  command in progress; completion pulse; SP wrapped during command.

Function
REQ-014 SHALL implement FSM states IDLE, XFER1, XFER2, DONE; o_busy = (state != IDLE).
REQ-015 In IDLE with i_start=1, SHALL latch i_cmd, i_wr_byte, i_pc and go to XFER1 (PUSH, POP, CALL, RET) or DONE (NOP, SP_WR, undefined codes).
REQ-016 i_start while o_busy=1 SHALL be ignored.
REQ-017 PUSH in XFER1: o_ram_op=WR_BYTE, o_ram_addr=SP+1, o_ram_wr_byte=latched byte, SP<=SP+1, then DONE.
REQ-018 CALL: XFER1 writes PC[7:0] at SP+1, XFER2 writes PC[15:8] at SP+2; SP advances by 1 each cycle; then DONE.
REQ-019 POP in XFER1: o_ram_op=RD_BYTE, o_ram_addr_r=SP, o_data<=i_ram_byte, SP<=SP-1, then DONE.
REQ-020 RET: XFER1 reads PC[15:8] at SP, XFER2 reads PC[7:0] at SP-1; SP decrements each cycle; o_pc updated after XFER2; then DONE.
REQ-021 SP_WR SHALL load SP<=i_wr_byte on the accepting edge, no RAM access.
REQ-022 DONE SHALL last exactly one cycle with o_done=1, then IDLE; command latency = 2 cycles (PUSH/POP), 3 (CALL/RET), 1 (SP_WR/NOP) from accept edge to o_done.
REQ-023 o_data and o_pc SHALL hold until overwritten by next POP/RET.
REQ-024 SP arithmetic SHALL be modulo 256 (FFh+1=00h, 00h-1=FFh); o_wrap SHALL be set in DONE if any wrap occurred during that command, else 0.
REQ-025 Outside XFER1/XFER2, o_ram_op SHALL be OP_RAM_NOP; address/data outputs are don't-care.
REQ-026 o_ram_op SHALL be forced to OP_RAM_NOP combinationally whenever i_rst_n=0 so no RAM write commits on a reset edge.

Reset
REQ-027 On i_rst_n=0 at a rising edge: state=IDLE, SP=SP_RESET, o_data=8'h00, o_pc=16'h0000, o_done=0, o_wrap=0, latched command=NOP.
REQ-028 Reset mid-command SHALL abort it: no o_done, no further RAM access, SP=SP_RESET.

Structure
REQ-029 STACK_CMD_LEN and command codes SHALL live in the shared Defines include alongside RAM_OP_LEN and OP_RAM_* codes (add OP_RAM_NOP there if absent).
REQ-030 SHALL be a single module, no sub-modules; outputs connect directly to the RAM write/read ports.

Verification
REQ-031 Reset, PUSH 8'hA5 -> write A5h at 08h, SP=08h, o_done 2 cycles after accept.
REQ-032 SP=07h, CALL i_pc=16'h1234 -> 34h at 08h, 12h at 09h, SP=09h; RET -> o_pc=1234h, SP=07h.
REQ-033 SP_WR 8'hFF then PUSH 8'h5A -> write at 00h, SP=00h, o_wrap=1 in DONE; POP -> o_data=5Ah, SP=FFh, o_wrap=1.
REQ-034 i_start pulsed with POP during busy CALL -> ignored; no RAM read, SP follows CALL only.
REQ-035 i_rst_n low during CALL XFER2 -> o_ram_op=NOP that cycle, 09h unwritten, SP=07h, no o_done.
